btn_debounce: RTL and testbench
===============================

# btn_debounce

Debounces one raw mechanical push-button and turns it into clean single-cycle press/release events plus a stable level. It sits directly upstream of the LED counter controller; `btn_press` is its step/enable input. The block synchronises the asynchronous pad signal, filters bounce with a qualification counter, and optionally generates auto-repeat presses while the button is held.

## Interface
- `DB_CYCLES`, default 50000: number of consecutive stable clock cycles required to accept a level change (1 ms at 50 MHz); legal range ≥ 1.
- `RPT_DELAY`, default 25000000: cycles held before the first auto-repeat (used only with `BTN_DEBOUNCE_REPEAT_EN`); ≥ 1.
- `RPT_PERIOD`, default 5000000: cycles between subsequent auto-repeats (used only with `BTN_DEBOUNCE_REPEAT_EN`); ≥ 1.
- `clk` input 1: single system clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `key_n` input 1: raw button pad, active-low (0 = pressed), asynchronous to `clk`.
- `btn_level` output 1: debounced state, 1 = pressed.
- `btn_press` output 1: one-cycle pulse on accepted press (and on each auto-repeat when enabled).
- `btn_release` output 1: one-cycle pulse on accepted release.

## Operation
- Synchroniser: two flops on `key_n`, both reset to 1 (released); the second-stage output `s` is the only signal used by the FSM.
- Debounce counter: width `$clog2(DB_CYCLES+1)`. It clears on every FSM transition and saturates, so it never wraps.
- FSM states and transitions:
  - RELEASED: `s`=0 → PRESS_CHK, clear counter.
  - PRESS_CHK: `s`=1 → RELEASED (bounce rejected, no pulse). Otherwise increment; when counter = `DB_CYCLES`-1 → PRESSED, register `btn_press`=1 for one cycle, `btn_level`=1.
  - PRESSED: `s`=1 → RELEASE_CHK, clear counter.
  - RELEASE_CHK: `s`=0 → PRESSED (bounce rejected, no pulse). When counter = `DB_CYCLES`-1 → RELEASED, `btn_release`=1 for one cycle, `btn_level`=0.
- `btn_press` and `btn_release` are never high in the same cycle. Each is never high for two consecutive cycles.
- A glitch shorter than `DB_CYCLES` cycles at `s` produces no event and leaves `btn_level` unchanged.
- Reset values: sync flops 1, state RELEASED, counters 0, `btn_level`=0, `btn_press`=0, `btn_release`=0.
- Reset asserted mid-qualification or mid-hold returns to RELEASED with no release pulse. A button still held after reset is re-qualified as a fresh press.

## Timing
- All outputs are registered; there is no combinational path from `key_n`.
- Press latency: let edge E0 be the first rising edge that samples `key_n`=0, with `key_n` held low from then on. `btn_press` is high in the cycle after edge E0+`DB_CYCLES`+2. That is 3 cycles of pipeline plus `DB_CYCLES` of qualification.
- Release latency: identical, measured from the first edge that samples `key_n`=1.
- `btn_level` changes on the same edge that raises the corresponding pulse.

## Configuration
- Macro: `BTN_DEBOUNCE_REPEAT_EN`.
- Defined:
  - A repeat counter of width `$clog2(max(RPT_DELAY,RPT_PERIOD)+1)` runs in PRESSED.
  - The counter clears on entry from PRESS_CHK, freezes in RELEASE_CHK, and resumes if the FSM returns to PRESSED.
  - The first extra `btn_press` pulse fires `RPT_DELAY` cycles after the initial press pulse. Later pulses fire every `RPT_PERIOD` cycles until release.
  - The counter clears on each repeat pulse and on reset.
- Undefined: no repeat logic is instantiated and `RPT_*` are ignored. Exactly one `btn_press` per accepted press.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `key_n`=0 → all outputs 0. Release reset with `DB_CYCLES`=4 → `btn_press` pulse in the cycle after the 7th edge from reset release, then `btn_level`=1.
- Clean press/release, `DB_CYCLES`=4: `key_n` low for 20 cycles, then high → exactly one `btn_press` at E0+6 and one `btn_release` at E0'+6. `btn_level` is high between them.
- Bounce, `DB_CYCLES`=4: `key_n` toggles low 3 cycles / high 1 cycle ×5, then stays low → no pulse during the toggling. A single `btn_press` 7 edges after the final fall.
- Release glitch: while pressed, `key_n` goes high for 3 cycles, then low → no `btn_release`; `btn_level` stays 1.
- Reset mid-hold: assert `rst_n`=0 while `btn_level`=1 → next cycle `btn_level`=0, with no `btn_release` pulse.
- Repeat (macro defined, `DB_CYCLES`=2, `RPT_DELAY`=10, `RPT_PERIOD`=4, `key_n` held low 30 cycles after the first pulse) → `btn_press` pulses at offsets 0, 10, 14, 18, 22, 26 from the first pulse. Without the macro: only the pulse at offset 0.

Source files
------------

// File: rtl/btn_debounce_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_if
// Groups the raw button pad and the debounced outputs of btn_debounce.
//   key_n       : raw push-button pad, active-low, asynchronous to clk
//   btn_level   : debounced level, 1 = pressed
//   btn_press   : one-cycle pulse per accepted press (and per auto-repeat)
//   btn_release : one-cycle pulse per accepted release
// Modports:
//   master : side that owns the pad and consumes the events (board / bench)
//   slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface btn_debounce_if;
    logic key_n;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    modport master (
        output key_n,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  key_n,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Debounces one mechanical push-button. The pad is synchronised with two
// flops, then a four-state FSM with a qualification counter accepts a level
// change only after the synchronised input has stayed at the new level long
// enough. Accepted changes produce single-cycle press/release pulses and a
// stable level. All outputs are registered.
//
// Ports:
//   clk    : system clock, all logic on the rising edge
//   rst_n  : synchronous active-low reset
//   btn    : btn_debounce_if.slave (key_n in; btn_level, btn_press,
//            btn_release out)
//
// Parameters:
//   DB_CYCLES  : stable cycles needed to accept a change (>= 1)
//   RPT_DELAY  : held cycles before the first auto-repeat (>= 1)
//   RPT_PERIOD : cycles between later auto-repeats (>= 1)
//
// Optional feature macro: BTN_DEBOUNCE_REPEAT_EN
//   Defined   : auto-repeat presses are generated while the button is held.
//   Undefined : no repeat logic; exactly one btn_press per accepted press,
//               RPT_DELAY / RPT_PERIOD are only range-checked.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES  = 50000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  logic          clk,
    input  logic          rst_n,
    btn_debounce_if.slave btn
);

    localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Elaboration-time guard on the parameter ranges.
    if (DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_param_check
        $error("btn_debounce: DB_CYCLES, RPT_DELAY and RPT_PERIOD must all be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; resets to "released" (pad high).
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn.key_n};
        end
    end

    assign s = sync_q[1];

    // ------------------------------------------------------------------
    // FSM state, qualification counter and registered outputs
    // ------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int               RPT_MAX         = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int               RPT_W           = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q,   rpt_cnt_d;
    // Set until the first repeat of the current hold has fired; selects
    // the long initial delay versus the shorter repeat period.
    logic             rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0] rpt_last;

    assign rpt_last = rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
`endif

        case (state_q)
            ST_RELEASED: begin
                if (!s) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = '0;
                end
            end

            ST_PRESS_CHK: begin
                if (s) begin
                    // Bounce: back to released without any event.
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
`ifdef BTN_DEBOUNCE_REPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
`endif
                end else if (cnt_q < CNT_LAST) begin
                    // Saturating increment: never wraps.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_PRESSED: begin
                if (s) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = '0;
                end
`ifdef BTN_DEBOUNCE_REPEAT_EN
                else if (rpt_cnt_q == rpt_last) begin
                    press_d     = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
`endif
            end

            ST_RELEASE_CHK: begin
                // The repeat counter is left untouched here so that a
                // rejected release glitch resumes the hold timing.
                if (!s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Scoreboard bench for btn_debounce. The driver applies directed and random
// pad waveforms; at every rising edge a behavioural model (two-sample pad
// delay plus "DB_CYCLES+1 consecutive disagreeing samples flip the level",
// with hold-time repeats when BTN_DEBOUNCE_REPEAT_EN is defined) pushes the
// expected outputs into a queue. A monitor pops and compares on each falling
// edge. Directed phases also check absolute press/release latencies.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    btn_debounce_if bus ();

    btn_debounce #(
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (bus)
    );

    typedef struct {
        bit level;
        bit press;
        bit rel;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    // DUT-observed event bookkeeping (actual values only)
    int first_press_edge = -1;
    int first_rel_edge   = -1;
    int rel_cnt          = 0;
    bit prev_press       = 1'b0;
    bit prev_rel         = 1'b0;

    // ---------------- reference model state ----------------
    bit m_s1 = 1'b1, m_s2 = 1'b1;
    bit m_level = 1'b0;
    int m_run = 0;     // consecutive samples disagreeing with m_level
    int m_held = 0;    // hold cycles since press / last repeat
    int m_thr = RD;    // hold cycles required for next repeat

    task automatic model_step(input bit r, input bit k, output exp_t e);
        bit s_now;
        bit want;
        int run_before;
        e.press = 1'b0;
        e.rel   = 1'b0;
        if (!r) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_level = 1'b0; m_run = 0; m_held = 0; m_thr = RD;
        end else begin
            s_now = m_s2;
            m_s2  = m_s1;
            m_s1  = k;
            want  = !s_now;
            run_before = m_run;
            if (want != m_level) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_level = want;
                    m_run   = 0;
                    if (want) begin
                        e.press = 1'b1;
                        m_held  = 0;
                        m_thr   = RD;
                    end else begin
                        e.rel = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
                if (m_level && run_before == 0) begin
                    m_held++;
                    if (m_held == m_thr) begin
                        e.press = 1'b1;
                        m_held  = 0;
                        m_thr   = RP;
                    end
                end
`endif
            end
        end
        e.level = m_level;
    endtask

    task automatic tick(input logic r, input logic k);
        exp_t e;
        rst_n     = r;
        bus.key_n = k;
        @(posedge clk);
        edge_cnt++;
        model_step(r, k, e);
        e.edge_no = edge_cnt;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic ticks(input logic r, input logic k, input int n);
        for (int i = 0; i < n; i++) tick(r, k);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 3;
            if (bus.btn_level !== e.level) begin
                failures++;
                $display("FAIL btn_level edge=%0d: actual=%b required=%b", e.edge_no, bus.btn_level, e.level);
            end
            if (bus.btn_press !== e.press) begin
                failures++;
                $display("FAIL btn_press edge=%0d: actual=%b required=%b", e.edge_no, bus.btn_press, e.press);
            end
            if (bus.btn_release !== e.rel) begin
                failures++;
                $display("FAIL btn_release edge=%0d: actual=%b required=%b", e.edge_no, bus.btn_release, e.rel);
            end
            checks++;
            if (bus.btn_press === 1'b1 && bus.btn_release === 1'b1) begin
                failures++;
                $display("FAIL press_and_release edge=%0d: actual=both high required=at most one", e.edge_no);
            end
            checks++;
            if ((bus.btn_press === 1'b1 && prev_press) || (bus.btn_release === 1'b1 && prev_rel)) begin
                failures++;
                $display("FAIL pulse_width edge=%0d: actual=two consecutive cycles required=single cycle", e.edge_no);
            end
            if (bus.btn_press === 1'b1) begin
                $display("event press   edge=%0d level=%b", e.edge_no, bus.btn_level);
                if (first_press_edge < 0) first_press_edge = e.edge_no;
            end
            if (bus.btn_release === 1'b1) begin
                $display("event release edge=%0d level=%b", e.edge_no, bus.btn_level);
                if (first_rel_edge < 0) first_rel_edge = e.edge_no;
                rel_cnt++;
            end
            prev_press = (bus.btn_press === 1'b1);
            prev_rel   = (bus.btn_release === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        int seg_len;
        bit seg_key;

        rst_n     = 1'b0;
        bus.key_n = 1'b1;

        // Reset held with the button already pressed: outputs stay 0,
        // then the press is qualified 7 edges after reset release.
        ticks(1'b0, 1'b0, 3);
        drain();
        check_int("reset_level", int'(bus.btn_level), 0);
        first_press_edge = -1;
        e0 = edge_cnt + 1;
        ticks(1'b1, 1'b0, 12);
        drain();
        check_int("reset_release_press_edge", first_press_edge, e0 + DB + 2);

        // Release, then a clean press / release pair.
        ticks(1'b1, 1'b1, 20);
        first_press_edge = -1;
        e0 = edge_cnt + 1;
        ticks(1'b1, 1'b0, 20);
        drain();
        check_int("clean_press_edge", first_press_edge, e0 + DB + 2);
        first_rel_edge = -1;
        e0 = edge_cnt + 1;
        ticks(1'b1, 1'b1, 20);
        drain();
        check_int("clean_release_edge", first_rel_edge, e0 + DB + 2);

        // Bounce: 5 x (3 low, 1 high), then held low.
        first_press_edge = -1;
        for (int i = 0; i < 5; i++) begin
            ticks(1'b1, 1'b0, 3);
            tick(1'b1, 1'b1);
        end
        e0 = edge_cnt + 1;
        ticks(1'b1, 1'b0, 12);
        drain();
        check_int("bounce_press_edge", first_press_edge, e0 + DB + 2);

        // Release glitch of 3 cycles while pressed.
        rel_cnt = 0;
        ticks(1'b1, 1'b1, 3);
        ticks(1'b1, 1'b0, 10);
        drain();
        check_int("glitch_release_count", rel_cnt, 0);
        check_int("glitch_level", int'(bus.btn_level), 1);

        // Reset while held: level drops, no release pulse.
        rel_cnt = 0;
        tick(1'b0, 1'b0);
        drain();
        check_int("midhold_reset_level", int'(bus.btn_level), 0);
        check_int("midhold_reset_release_count", rel_cnt, 0);
        ticks(1'b1, 1'b1, 12);

`ifdef BTN_DEBOUNCE_REPEAT_EN
        // Long hold with a short release glitch in the middle.
        ticks(1'b1, 1'b0, 25);
        ticks(1'b1, 1'b1, 2);
        ticks(1'b1, 1'b0, 30);
        ticks(1'b1, 1'b1, 12);
`endif

        // Randomised pad waveform: mostly short bounces, some long holds,
        // occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            seg_key = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) seg_len = $urandom_range(DB + 3, 35);
            else                           seg_len = $urandom_range(1, DB + 2);
            if ($urandom_range(0, 49) == 0) ticks(1'b0, seg_key, $urandom_range(1, 2));
            ticks(1'b1, seg_key, seg_len);
        end
        ticks(1'b1, 1'b1, 12);
        drain();
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
